// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared opcode constants and immediate-source enum for the decode stage
package pipeline_pkg;

  localparam logic [6:0] RV_OP_IMM = 7'b0010011;
  localparam logic [6:0] RV_LOAD   = 7'b0000011;
  localparam logic [6:0] RV_JALR   = 7'b1100111;
  localparam logic [6:0] RV_STORE  = 7'b0100011;
  localparam logic [6:0] RV_BRANCH = 7'b1100011;
  localparam logic [6:0] RV_LUI    = 7'b0110111;
  localparam logic [6:0] RV_AUIPC  = 7'b0010111;
  localparam logic [6:0] RV_JAL    = 7'b1101111;

  // ARM op class lives in instr[27:26]
  localparam logic [1:0] ARM_OP_DP  = 2'b00;
  localparam logic [1:0] ARM_OP_MEM = 2'b01;
  localparam logic [1:0] ARM_OP_BR  = 2'b10;

  typedef enum logic [3:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_ARM_DP,
    IMM_ARM_MEM,
    IMM_ARM_BR,
    IMM_NONE
  } imm_src_t;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - shared register file with write-first bypass, x0 and ARM r15 rules
module regfile #(
  parameter int REGS = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [XLEN-1:0] pc8,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] r_mem [REGS];
  logic            w_wr_ok;

  assign w_wr_ok = we && (arm ? (wa < 5'd15) : (wa != 5'd0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wa] <= wd;
    end
  end

  // r15 reads the pipeline PC and is never bypassed since it is never writable
  always_comb begin
    rd1 = r_mem[ra1];
    if (arm && ra1 == 5'd15)          rd1 = pc8;
    else if (w_wr_ok && wa == ra1)    rd1 = wd;
    else if (!arm && ra1 == 5'd0)     rd1 = '0;
  end

  always_comb begin
    rd2 = r_mem[ra2];
    if (arm && ra2 == 5'd15)          rd2 = pc8;
    else if (w_wr_ok && wa == ra2)    rd2 = wd;
    else if (!arm && ra2 == 5'd0)     rd2 = '0;
  end

endmodule

// File: rtl/stage_d.sv
// rtl/stage_d.sv - ARM/RISC-V decode stage: F/D register, operand read, index and immediate decode
// Define STAGE_D_ARM_EN to honour the arm input; otherwise decode is RISC-V only.
module stage_d
  import pipeline_pkg::*;
#(
  parameter int REGS = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic [31:0]     InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [4:0]      RdD,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ImmExtD
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic            r_valid;
  logic            w_arm;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  imm_src_t        w_imm_src;
  logic [31:0]     w_imm;

`ifdef STAGE_D_ARM_EN
  assign w_arm = arm;
`else
  logic w_unused_arm;
  assign w_unused_arm = arm;
  assign w_arm        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst || FlushD) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!StallD) begin
      r_instr <= InstrF;
      r_pc    <= PCF;
      r_pc4   <= PCPlus4F;
      r_valid <= 1'b1;
    end
  end

  always_comb begin
    w_rs1 = r_instr[19:15];
    w_rs2 = r_instr[24:20];
    w_rd  = r_instr[11:7];
`ifdef STAGE_D_ARM_EN
    if (w_arm) begin
      w_rs1 = (r_instr[27:26] == ARM_OP_BR)  ? 5'd15 : {1'b0, r_instr[19:16]};
      w_rs2 = (r_instr[27:26] == ARM_OP_MEM) ? {1'b0, r_instr[15:12]} : {1'b0, r_instr[3:0]};
      w_rd  = (r_instr[27:26] == ARM_OP_BR && r_instr[24]) ? 5'd14 : {1'b0, r_instr[15:12]};
    end
`endif
  end

  always_comb begin
    w_imm_src = IMM_NONE;
    if (!w_arm) begin
      case (r_instr[6:0])
        RV_OP_IMM, RV_LOAD, RV_JALR: w_imm_src = IMM_I;
        RV_STORE:                    w_imm_src = IMM_S;
        RV_BRANCH:                   w_imm_src = IMM_B;
        RV_LUI, RV_AUIPC:            w_imm_src = IMM_U;
        RV_JAL:                      w_imm_src = IMM_J;
        default:                     w_imm_src = IMM_NONE;
      endcase
    end
`ifdef STAGE_D_ARM_EN
    else begin
      case (r_instr[27:26])
        ARM_OP_DP:  w_imm_src = IMM_ARM_DP;
        ARM_OP_MEM: w_imm_src = IMM_ARM_MEM;
        ARM_OP_BR:  w_imm_src = IMM_ARM_BR;
        default:    w_imm_src = IMM_NONE;
      endcase
    end
`endif
  end

  always_comb begin
    w_imm = '0;
    case (w_imm_src)
      IMM_I: w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
      IMM_S: w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      IMM_B: w_imm = {{20{r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
      IMM_U: w_imm = {r_instr[31:12], 12'b0};
      IMM_J: w_imm = {{12{r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
`ifdef STAGE_D_ARM_EN
      // rotate right by shifting a doubled copy, so a zero rotation needs no special case
      IMM_ARM_DP:  w_imm = 32'({2{24'b0, r_instr[7:0]}} >> {r_instr[11:8], 1'b0});
      IMM_ARM_MEM: w_imm = {20'b0, r_instr[11:0]};
      IMM_ARM_BR:  w_imm = {{6{r_instr[23]}}, r_instr[23:0], 2'b00};
`endif
      default: w_imm = '0;
    endcase
  end

  regfile #(
    .REGS (REGS),
    .XLEN (XLEN)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .arm (w_arm),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW),
    .ra1 (w_rs1),
    .ra2 (w_rs2),
    .pc8 (r_pc4 + XLEN'(4)),
    .rd1 (RD1D),
    .rd2 (RD2D)
  );

  assign InstrD   = r_instr;
  assign PCD      = r_pc;
  assign PCPlus4D = r_pc4;
  assign ValidD   = r_valid;
  assign Rs1D     = w_rs1;
  assign Rs2D     = w_rs2;
  assign RdD      = w_rd;
  assign ImmExtD  = w_imm;

endmodule
